debug_run_controller: RTL and testbench

//  Sequences the MIPS pipeline for the PC debugger. Decodes command bytes popped from the UART

---
 rtl/debug_run_controller_if.sv | 34 +++
 rtl/debug_run_controller.sv | 184 ++++++++++++++++++
 tb/tb_debug_run_controller.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_run_controller_if.sv
`default_nettype none
// ============================================================================
//  Module  : debug_run_controller_if
//  Brief   : Bundle between the debug run controller, the UART rx FIFO,
//            the MIPS pipeline and the debug dump transmitter.
//            master = controller side, slave = environment side.
//  Revision: 1.0  initial release
// ============================================================================
interface debug_run_controller_if;
    logic [7:0]  r_data;            // head byte of rx FIFO
    logic        rx_ready;          // rx FIFO not empty
    logic        rd_uart;           // pop strobe
    logic        program_finished;  // pipeline reached end of program
    logic        data_sent;         // transmitter finished dump
    logic        pipeline_reset;    // synchronous pipeline reset
    logic        pipeline_en;       // pipeline clock enable
    logic        send_signal;       // start dump transmission
    logic [31:0] cycle_count;       // enable cycles since last reset command
    logic        run_timeout;       // RUN ended by watchdog
    logic [2:0]  current_state;     // FSM state for the dump

    modport master (
        input  r_data, rx_ready, program_finished, data_sent,
        output rd_uart, pipeline_reset, pipeline_en, send_signal,
               cycle_count, run_timeout, current_state
    );

    modport slave (
        output r_data, rx_ready, program_finished, data_sent,
        input  rd_uart, pipeline_reset, pipeline_en, send_signal,
               cycle_count, run_timeout, current_state
    );
endinterface
`default_nettype wire

// File: rtl/debug_run_controller.sv
`default_nettype none
// ============================================================================
//  Module  : debug_run_controller
//  Brief   : Decodes debugger command bytes ('r' reset, 's' step, 'c' run)
//            from the UART rx FIFO, drives pipeline reset / clock enable and
//            triggers one debug dump after every step or run.
//            Optional RUN watchdog enabled by defining DBG_TIMEOUT_EN.
//  Revision: 1.0  initial release
// ============================================================================
module debug_run_controller #(
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned RUN_TIMEOUT = 1000000,
    parameter logic [7:0]  CMD_RESET   = 8'h72,
    parameter logic [7:0]  CMD_STEP    = 8'h73,
    parameter logic [7:0]  CMD_RUN     = 8'h63
) (
    input  wire logic              clk,
    input  wire logic              global_reset_n,
    debug_run_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_RESET   = 3'd2,
        S_STEP    = 3'd3,
        S_RUN     = 3'd4,
        S_SEND    = 3'd5,
        S_WAIT_TX = 3'd6
    } state_t;

    // Counter holds the remaining RESET cycles minus one.
    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);

    // Elaboration-time sanity check of the configuration.
    if (RST_CYCLES < 1 || RUN_TIMEOUT < 1) begin : g_param_check
        $error("debug_run_controller: RST_CYCLES and RUN_TIMEOUT must be >= 1");
    end

    state_t           state_q;
    logic [7:0]       cmd_q;
    logic [RST_W-1:0] rst_cnt_q;
    logic [31:0]      cycle_count_q;
    logic [31:0]      cycle_count_d;
    logic             run_timeout_q;
    logic             pipeline_reset_q;
    logic             send_signal_q;

    logic             abort_req;
    logic             pop_req;
    logic             run_en;

`ifdef DBG_TIMEOUT_EN
    logic [31:0]      run_cnt_q;
    logic             timeout_req;
    // Watchdog fires once RUN_TIMEOUT enable cycles have been issued.
    assign timeout_req = (state_q == S_RUN) && (run_cnt_q >= RUN_TIMEOUT);
`endif

    // An 'r' at the FIFO head while running aborts the run immediately.
    assign abort_req = (state_q == S_RUN) && bus.rx_ready && (bus.r_data == CMD_RESET);
    assign pop_req   = ((state_q == S_IDLE) && bus.rx_ready) || abort_req;

    // Enable is gated combinationally so it drops in the very cycle the
    // pipeline reports completion (or the run is aborted / times out).
    always_comb begin
        run_en = 1'b0;
        if (state_q == S_STEP) begin
            run_en = !bus.program_finished;
        end else if (state_q == S_RUN) begin
            run_en = !bus.program_finished && !abort_req;
`ifdef DBG_TIMEOUT_EN
            if (timeout_req) begin
                run_en = 1'b0;
            end
`endif
        end
    end

    assign cycle_count_d = (run_en && (cycle_count_q != 32'hFFFF_FFFF))
                         ? cycle_count_q + 32'd1 : cycle_count_q;

    // Command sequencer with registered reset / send outputs.
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q          <= S_RESET;
            rst_cnt_q        <= RST_LOAD;
            cmd_q            <= 8'h00;
            cycle_count_q    <= 32'd0;
            run_timeout_q    <= 1'b0;
            pipeline_reset_q <= 1'b1;
            send_signal_q    <= 1'b0;
`ifdef DBG_TIMEOUT_EN
            run_cnt_q        <= 32'd0;
`endif
        end else begin
            pipeline_reset_q <= 1'b0;
            send_signal_q    <= 1'b0;
            cycle_count_q    <= cycle_count_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_ready) begin
                        cmd_q   <= bus.r_data;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (cmd_q == CMD_RESET) begin
                        state_q          <= S_RESET;
                        rst_cnt_q        <= RST_LOAD;
                        pipeline_reset_q <= 1'b1;
                        run_timeout_q    <= 1'b0;
                    end else if (cmd_q == CMD_STEP) begin
                        state_q       <= S_STEP;
                        run_timeout_q <= 1'b0;
                    end else if (cmd_q == CMD_RUN) begin
                        state_q       <= S_RUN;
                        run_timeout_q <= 1'b0;
`ifdef DBG_TIMEOUT_EN
                        run_cnt_q     <= 32'd0;
`endif
                    end else begin
                        state_q <= S_IDLE;   // unknown byte is dropped
                    end
                end
                S_RESET: begin
                    cycle_count_q <= 32'd0;
                    if (rst_cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        rst_cnt_q        <= rst_cnt_q - RST_W'(1);
                        pipeline_reset_q <= 1'b1;
                    end
                end
                S_STEP: begin
                    state_q       <= S_SEND;
                    send_signal_q <= 1'b1;
                end
                S_RUN: begin
                    if (abort_req) begin
                        state_q          <= S_RESET;
                        rst_cnt_q        <= RST_LOAD;
                        pipeline_reset_q <= 1'b1;
                    end else if (bus.program_finished) begin
                        state_q       <= S_SEND;
                        send_signal_q <= 1'b1;
                    end else begin
`ifdef DBG_TIMEOUT_EN
                        if (timeout_req) begin
                            state_q       <= S_SEND;
                            send_signal_q <= 1'b1;
                            run_timeout_q <= 1'b1;
                        end else begin
                            run_cnt_q <= run_cnt_q + 32'd1;
                        end
`endif
                    end
                end
                S_SEND: begin
                    state_q <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (bus.data_sent) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_uart        = pop_req;
    assign bus.pipeline_en    = run_en;
    assign bus.pipeline_reset = pipeline_reset_q;
    assign bus.send_signal    = send_signal_q;
    assign bus.cycle_count    = cycle_count_q;
    assign bus.run_timeout    = run_timeout_q;
    assign bus.current_state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_run_controller.sv
`default_nettype none
// ============================================================================
//  Module  : tb_debug_run_controller
//  Brief   : Self-checking bench for debug_run_controller: directed command
//            table, hand-written reset sequences and randomized commands
//            checked against a transaction-level model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_debug_run_controller;

    localparam int RSTC  = 4;
    localparam int TMO   = 16;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic global_reset_n = 1'b0;
    always #5 clk = ~clk;

    debug_run_controller_if bus();

    debug_run_controller #(
        .RST_CYCLES (RSTC),
        .RUN_TIMEOUT(TMO),
        .CMD_RESET  (8'h72),
        .CMD_STEP   (8'h73),
        .CMD_RUN    (8'h63)
    ) dut (
        .clk           (clk),
        .global_reset_n(global_reset_n),
        .bus           (bus)
    );

    typedef struct {
        logic [7:0] cmd;
        bit         push;
        logic [7:0] extra;
        int         pf;
        int         ab;
        int         e_en;
        int         e_send;
        int         e_prst;
        int         e_pop;
        longint     e_count;
        int         e_dur;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int viol = 0;

    logic [7:0] fifo[$];
    bit  pop_pend = 0;
    bit  prev_pop = 0;
    int  cyc = 0;
    int  tot_en = 0, tot_send = 0, tot_prst = 0, tot_pop = 0;
    int  base_en = 0;
    int  pf_limit = NEVER;
    int  ab_after = -1;
    bit  ab_arm = 0, ab_done = 0;
    bit  tx_busy = 0;
    int  tx_cnt = 0;
    int  tx_lat_max = 0;
    bit  spurious_en = 0;
    int  carry_pop = 0;
    int  carry_cyc = 0;
    longint m_count = 0;
    bit  m_to = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.rx_ready = (fifo.size() != 0);
        bus.r_data   = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    // One clock: update environment after the edge, sample at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_pend && fifo.size() != 0) void'(fifo.pop_front());
        if (ab_arm && !ab_done && (tot_en - base_en) >= ab_after) begin
            fifo.push_back(8'h72);
            ab_done = 1;
        end
        bus.program_finished = ((tot_en - base_en) >= pf_limit);
        bus.data_sent = 1'b0;
        if (tx_busy) begin
            if (tx_cnt == 0) begin
                bus.data_sent = 1'b1;
                tx_busy = 0;
            end else begin
                tx_cnt--;
            end
        end else if (spurious_en && $urandom_range(0, 7) == 0) begin
            bus.data_sent = 1'b1;
        end
        drive_fifo();
        @(negedge clk);
        cyc++;
        if (bus.pipeline_en) tot_en++;
        if (bus.pipeline_reset) tot_prst++;
        if (bus.pipeline_en && bus.pipeline_reset) viol++;
        if (bus.send_signal) begin
            tot_send++;
            if (tx_busy) viol++;
            tx_busy = 1;
            tx_cnt  = $urandom_range(0, tx_lat_max);
        end
        if (bus.rd_uart) begin
            tot_pop++;
            if (!bus.rx_ready || prev_pop) viol++;
            if (bus.current_state == 3'd5 || bus.current_state == 3'd6) viol++;
            if (bus.current_state == 3'd4 && bus.r_data != 8'h72) viol++;
        end
        pop_pend = bus.rd_uart;
        prev_pop = bus.rd_uart;
    endtask

    // Transaction-level prediction of one command's visible effect.
    task automatic model(input logic [7:0] cmd, input int pf, input int ab,
                         output int en, output int snd, output int prst,
                         output int pops, output int dur);
        int n;
        en = 0; snd = 0; prst = 0; pops = 1; dur = -1;
        if (cmd == 8'h72) begin
            prst = RSTC; m_count = 0; m_to = 0;
        end else if (cmd == 8'h73) begin
            en = (pf > 0) ? 1 : 0;
            snd = 1; m_to = 0;
            m_count = m_count + en;
        end else if (cmd == 8'h63) begin
            n = pf;
            if (ab >= 0 && ab < n) n = ab;
`ifdef DBG_TIMEOUT_EN
            if (TMO < n) n = TMO;
`endif
            en = n; m_to = 0;
            if (ab >= 0 && ab == n) begin
                prst = RSTC; pops = 2; m_count = 0;
            end else begin
                snd = 1;
                m_count = m_count + n;
`ifdef DBG_TIMEOUT_EN
                m_to = (pf != n);
`endif
            end
        end else begin
            dur = 2;
        end
        if (m_count > 64'h0000_0000_FFFF_FFFF) m_count = 64'h0000_0000_FFFF_FFFF;
    endtask

    task automatic run_cmd(input logic [7:0] cmd, input bit push, input logic [7:0] extra,
                           input int pf, input int ab, input int tlat,
                           input int e_en, input int e_send, input int e_prst, input int e_pop,
                           input longint e_count, input bit e_to, input int e_dur,
                           input string tag);
        int b_send, b_prst, b_pop, pop_cyc, n;
        bit started, done;
        base_en  = tot_en;
        b_send   = tot_send;
        b_prst   = tot_prst;
        b_pop    = tot_pop - carry_pop;
        pf_limit = pf;
        ab_after = ab;
        ab_arm   = (ab >= 0);
        ab_done  = 0;
        tx_lat_max = tlat;
        started  = (carry_pop != 0);
        pop_cyc  = carry_cyc;
        if (push) begin
            fifo.push_back(cmd);
            if (extra != 8'h00) fifo.push_back(extra);
        end
        done = 0;
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
            if (started && bus.current_state == 3'd0) done = 1;
            else if (bus.rd_uart && !started) begin
                started = 1;
                pop_cyc = cyc;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s wait: no return to IDLE within 400 cycles (state %0d)", tag, bus.current_state);
        end
        carry_pop = bus.rd_uart ? 1 : 0;
        carry_cyc = cyc;
        chk({tag, " en_cycles"},   tot_en - base_en, e_en);
        chk({tag, " send_pulses"}, tot_send - b_send, e_send);
        chk({tag, " reset_cycles"}, tot_prst - b_prst, e_prst);
        chk({tag, " pops"},        (tot_pop - carry_pop) - b_pop, e_pop);
        chk({tag, " cycle_count"}, bus.cycle_count, e_count);
        chk({tag, " run_timeout"}, bus.run_timeout, e_to);
        if (e_dur >= 0) chk({tag, " discard_cycles"}, cyc - pop_cyc, e_dur);
    endtask

    initial begin
        vec_t vecs[10];
        int n, n_prst;
        int en, snd, prst, pops, dur;

        vecs[0] = '{8'h72, 1'b1, 8'h00, NEVER, -1, 0,  0, 4, 1, 0,  -1};
        vecs[1] = '{8'h73, 1'b1, 8'h00, NEVER, -1, 1,  1, 0, 1, 1,  -1};
        vecs[2] = '{8'h72, 1'b1, 8'h00, NEVER, -1, 0,  0, 4, 1, 0,  -1};
        vecs[3] = '{8'h63, 1'b1, 8'h73, 10,    -1, 10, 1, 0, 1, 10, -1};
        vecs[4] = '{8'h73, 1'b0, 8'h00, NEVER, -1, 1,  1, 0, 1, 11, -1};
        vecs[5] = '{8'h63, 1'b1, 8'h00, NEVER,  5, 5,  0, 4, 2, 0,  -1};
        vecs[6] = '{8'h41, 1'b1, 8'h00, NEVER, -1, 0,  0, 0, 1, 0,   2};
        vecs[7] = '{8'h73, 1'b1, 8'h00, 0,     -1, 0,  1, 0, 1, 0,  -1};
        vecs[8] = '{8'h63, 1'b1, 8'h00, 0,     -1, 0,  1, 0, 1, 0,  -1};
        vecs[9] = '{8'h63, 1'b1, 8'h00, 3,     -1, 3,  1, 0, 1, 3,  -1};

        bus.r_data = 8'h00;
        bus.rx_ready = 1'b0;
        bus.program_finished = 1'b0;
        bus.data_sent = 1'b0;

        // Power-up reset values
        repeat (2) @(negedge clk);
        chk("por pipeline_reset", bus.pipeline_reset, 1);
        chk("por pipeline_en",    bus.pipeline_en, 0);
        chk("por send_signal",    bus.send_signal, 0);
        chk("por rd_uart",        bus.rd_uart, 0);
        chk("por cycle_count",    bus.cycle_count, 0);
        chk("por run_timeout",    bus.run_timeout, 0);
        chk("por state",          bus.current_state, 2);

        // Release: pipeline reset held RSTC cycles, then IDLE
        global_reset_n = 1'b1;
        n_prst = bus.pipeline_reset ? 1 : 0;
        n = 0;
        while (bus.current_state != 3'd0 && n < 20) begin
            tick();
            n++;
            if (bus.pipeline_reset) n_prst++;
        end
        chk("release reset_cycles", n_prst, RSTC);
        chk("release state",        bus.current_state, 0);
        chk("release sends",        tot_send, 0);
        chk("release pops",         tot_pop, 0);

        // Directed command table
        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].cmd, vecs[i].push, vecs[i].extra, vecs[i].pf, vecs[i].ab, 2,
                    vecs[i].e_en, vecs[i].e_send, vecs[i].e_prst, vecs[i].e_pop,
                    vecs[i].e_count, 1'b0, vecs[i].e_dur, $sformatf("vec%0d", i));
        end

`ifdef DBG_TIMEOUT_EN
        // Watchdog ends a run that never finishes; next command clears the flag
        run_cmd(8'h63, 1'b1, 8'h00, NEVER, -1, 1, TMO, 1, 0, 1, 3 + TMO, 1'b1, -1, "timeout_run");
        run_cmd(8'h73, 1'b1, 8'h00, NEVER, -1, 1, 1,   1, 0, 1, 4 + TMO, 1'b0, -1, "timeout_clear");
`endif

        // Asynchronous reset in the middle of a run
        pf_limit = NEVER;
        ab_arm = 0;
        base_en = tot_en;
        fifo.push_back(8'h63);
        repeat (8) tick();
        chk("midrun state",       bus.current_state, 4);
        chk("midrun pipeline_en", bus.pipeline_en, 1);
        #2;
        global_reset_n = 1'b0;
        #1;
        chk("async pipeline_en",    bus.pipeline_en, 0);
        chk("async pipeline_reset", bus.pipeline_reset, 1);
        chk("async send_signal",    bus.send_signal, 0);
        chk("async cycle_count",    bus.cycle_count, 0);
        chk("async state",          bus.current_state, 2);
        @(negedge clk);
        global_reset_n = 1'b1;
        n = 0;
        while (bus.current_state != 3'd0 && n < 20) begin
            tick();
            n++;
        end
        chk("async recover state", bus.current_state, 0);
        m_count = 0;
        m_to = 0;
        carry_pop = 0;

        // Randomized commands against the transaction model
        spurious_en = 1;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] c;
            int r, pf, ab;
            r = $urandom_range(0, 9);
            if (r < 2)      c = 8'h72;
            else if (r < 5) c = 8'h73;
            else if (r < 8) c = 8'h63;
            else begin
                do c = 8'($urandom_range(0, 255));
                while (c == 8'h72 || c == 8'h73 || c == 8'h63);
            end
            pf = $urandom_range(0, 20);
            ab = (c == 8'h63 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : -1;
            model(c, pf, ab, en, snd, prst, pops, dur);
            run_cmd(c, 1'b1, 8'h00, pf, ab, $urandom_range(0, 3),
                    en, snd, prst, pops, m_count, m_to, dur, $sformatf("rnd%0d", k));
        end

        chk("protocol_invariants", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
